// File: rtl/pintor_objetivo.sv
// Target placement and reaction-time measurement for one game round.
// Free-running LFSR picks the position; a prescaled counter times the player.
module pintor_objetivo #(
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         TICK_DIV   = 50000,
  parameter int         TIME_WIDTH = 16
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iEnableLFSR,
  input  logic                  iPintar,
  input  logic                  iResetPintar,
  output logic [3:0]            oPosX,
  output logic [3:0]            oPosY,
  output logic                  oVisible,
  output logic [TIME_WIDTH-1:0] oTiempo,
  output logic                  oValido
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]      PRE_ONE  = PRE_W'(1);
  localparam logic [TIME_WIDTH-1:0] T_MAX    = '1;
  localparam logic [TIME_WIDTH-1:0] T_ONE    = TIME_WIDTH'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] VISIBLE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [7:0]       lfsr;
  logic [PRE_W-1:0] prescaler;
  logic             lfsrStep;

  // Idle time spent waiting for the player is the entropy source.
  assign lfsrStep = iEnableLFSR || (state == IDLE);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      lfsr      <= SEED;
      state     <= IDLE;
      oPosX     <= 4'd0;
      oPosY     <= 4'd0;
      oVisible  <= 1'b0;
      oTiempo   <= '0;
      oValido   <= 1'b0;
      prescaler <= '0;
    end else begin
      if (lfsr == 8'h00)
        lfsr <= SEED;
      else if (lfsrStep)
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      case (state)
        IDLE: begin
          if (iPintar) begin
            oPosX     <= lfsr[3:0];
            oPosY     <= lfsr[7:4];
            prescaler <= '0;
            oTiempo   <= '0;
            oVisible  <= 1'b1;
            state     <= VISIBLE;
          end
        end
        VISIBLE: begin
          if (iResetPintar) begin
            oVisible <= 1'b0;
            oValido  <= 1'b1;
            state    <= DONE;
          end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            // Saturate instead of wrapping so a slow player never scores fast.
            if (oTiempo != T_MAX)
              oTiempo <= oTiempo + T_ONE;
          end else begin
            prescaler <= prescaler + PRE_ONE;
          end
        end
        DONE: begin
          oValido <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          oVisible <= 1'b0;
          oValido  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
